// File: rtl/ft601_mcfifo_rd_depacketizer_if.sv
// Signal bundle between the FT601 read side, the depacketizer and the user stream.
// Output stream: a word transfers on every rising clk edge where out_valid && out_ready; out_* hold while stalled.
interface ft601_mcfifo_rd_depacketizer_if;
    logic [31:0] in_data;
    logic [3:0]  in_be;
    logic        in_valid;
    logic        in_burst_end;
    logic        in_has_packet_space;
    logic [31:0] out_data;
    logic [3:0]  out_be;
    logic        out_last;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_pkt_count;
    logic        overflow;

    modport master (
        output in_data, in_be, in_valid, in_burst_end, out_ready,
        input  in_has_packet_space, out_data, out_be, out_last, out_valid,
               out_pkt_count, overflow
    );

    modport slave (
        input  in_data, in_be, in_valid, in_burst_end, out_ready,
        output in_has_packet_space, out_data, out_be, out_last, out_valid,
               out_pkt_count, overflow
    );
endinterface

// File: rtl/ft601_mcfifo_rd_depacketizer.sv
// FT601 receive-channel buffer: stages incoming words until their last flag is known,
// stores {last,be,data} in a circular RAM and presents packets first-word-fall-through.
module ft601_mcfifo_rd_depacketizer #(
    parameter int CAPACITY        = 8192,
    parameter int MAX_PACKET_SIZE = 1024
) (
    input logic                           clk,
    input logic                           reset_n,
    ft601_mcfifo_rd_depacketizer_if.slave bus
);

    localparam int DEPTH     = CAPACITY / 4;
    localparam int AW        = $clog2(DEPTH);
    localparam int CW        = $clog2(DEPTH + 1);
    localparam int PKT_WORDS = MAX_PACKET_SIZE / 4;
    localparam int PW        = $clog2(PKT_WORDS + 1);

    localparam logic [CW-1:0] FULL_COUNT   = CW'(DEPTH);
    localparam logic [CW-1:0] SPACE_LIMIT  = CW'(DEPTH - PKT_WORDS);
    localparam logic [PW-1:0] PKT_LAST_IDX = PW'(PKT_WORDS - 1);

    logic [36:0]   mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;

    logic          stg_valid;
    logic          stg_last;
    logic [31:0]   stg_data;
    logic [3:0]    stg_be;
    logic [PW-1:0] pkt_words;

    logic [CW-1:0] word_count;
    logic          s1_valid;
    logic [36:0]   s1_q;
    logic          out_valid_r;
    logic [36:0]   out_q;
    logic [15:0]   pkt_count;
    logic          overflow_r;
    logic          has_space_r;

    logic accept;
    logic drop;
    logic commit;
    logic commit_last;
    logic new_last;
    logic out_fire;
    logic out_load;
    logic rd_en;

    always_comb begin
        accept      = 1'b0;
        drop        = 1'b0;
        commit      = 1'b0;
        commit_last = 1'b0;
        new_last    = 1'b0;
        out_fire    = 1'b0;
        out_load    = 1'b0;
        rd_en       = 1'b0;

        accept = bus.in_valid && (word_count != FULL_COUNT);
        drop   = bus.in_valid && !accept;
        // A dropped word behaves like an empty cycle, so a coincident burst end still closes the packet.
        commit      = stg_valid && (stg_last || accept || bus.in_burst_end);
        commit_last = stg_last || (bus.in_burst_end && !accept);
        new_last    = bus.in_burst_end || (pkt_words == PKT_LAST_IDX);

        out_fire = out_valid_r && bus.out_ready;
        out_load = s1_valid && (!out_valid_r || bus.out_ready);
        rd_en    = (wr_ptr != rd_ptr) && (!s1_valid || out_load);
    end

    always_ff @(posedge clk) begin
        if (commit) begin
            mem[wr_ptr[AW-1:0]] <= {commit_last, stg_be, stg_data};
        end
        if (rd_en) begin
            s1_q <= mem[rd_ptr[AW-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stg_valid   <= 1'b0;
            stg_last    <= 1'b0;
            stg_data    <= '0;
            stg_be      <= '0;
            pkt_words   <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            word_count  <= '0;
            s1_valid    <= 1'b0;
            out_valid_r <= 1'b0;
            out_q       <= '0;
            pkt_count   <= '0;
            overflow_r  <= 1'b0;
            has_space_r <= 1'b1;
        end else begin
            if (accept) begin
                stg_valid <= 1'b1;
                stg_data  <= bus.in_data;
                stg_be    <= bus.in_be;
                stg_last  <= new_last;
            end else if (commit) begin
                stg_valid <= 1'b0;
                stg_last  <= 1'b0;
            end

            if (accept) begin
                pkt_words <= new_last ? '0 : pkt_words + PW'(1);
            end else if (bus.in_burst_end) begin
                pkt_words <= '0;
            end

            if (commit) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end

            if (rd_en) begin
                s1_valid <= 1'b1;
            end else if (out_load) begin
                s1_valid <= 1'b0;
            end

            if (out_load) begin
                out_valid_r <= 1'b1;
                out_q       <= s1_q;
            end else if (out_fire) begin
                out_valid_r <= 1'b0;
            end

            word_count <= word_count + CW'(accept) - CW'(out_fire);

            case ({commit && commit_last, out_fire && out_q[36]})
                2'b10:   pkt_count <= pkt_count + 16'd1;
                2'b01:   pkt_count <= pkt_count - 16'd1;
                default: pkt_count <= pkt_count;
            endcase

            if (drop) begin
                overflow_r <= 1'b1;
            end
            // Follows word_count by one cycle; free space is judged in whole packets.
            has_space_r <= (word_count <= SPACE_LIMIT);
        end
    end

    assign bus.out_data            = out_q[31:0];
    assign bus.out_be              = out_q[35:32];
    assign bus.out_last            = out_q[36];
    assign bus.out_valid           = out_valid_r;
    assign bus.out_pkt_count       = pkt_count;
    assign bus.overflow            = overflow_r;
    assign bus.in_has_packet_space = has_space_r;

endmodule
